// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package if_pkg;

  localparam int ADDR_W_D = 10;
  localparam int DATA_W_D = 32;
  localparam int DEPTH_D  = 4;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic [ADDR_W_D-1:0] pc;
    logic [DATA_W_D-1:0] inst;
  } fifo_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, inst}, with a flush that
// overrides any push or pop in the same cycle.
module if_fifo
  import if_pkg::*;
#(
  parameter int W     = ADDR_W_D + DATA_W_D,
  parameter int DEPTH = DEPTH_D,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic [PW:0]  o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push & ~i_flush;
  assign w_pop   = i_pop & ~i_flush & (r_cnt != '0);
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch PC generator, imem read port and prefetch queue to decode.
// Optional IF_PERF_CNT_EN adds perf_fetched / perf_starve counters.
module inst_fetch_queue
  import if_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int DATA_W   = DATA_W_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_re,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_starve
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [PW+1:0] DEPTH_L = (PW+2)'(DEPTH);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [PW:0]       w_count;
  logic [PW+1:0]     w_used;
  logic [EW-1:0]     w_head;

  // Credit counts the in-flight read so a response always has a slot.
  assign w_used = {1'b0, w_count} + {{(PW+1){1'b0}}, r_inflight};

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    unique case (r_state)
      S_BOOT:  w_next = redirect_valid ? S_FLUSH : S_RUN;
      S_RUN: begin
        if (redirect_valid) w_next = S_FLUSH;
        else w_issue = (w_used < DEPTH_L);
      end
      S_FLUSH: w_next = redirect_valid ? S_FLUSH : S_RUN;
      default: w_next = S_BOOT;
    endcase
  end

  assign w_push = r_inflight & ~redirect_valid;
  assign w_pop  = if_valid & id_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= ADDR_W'(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  if_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_wdata ({r_inflight_pc, imem_rdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign imem_re   = w_issue;
  assign imem_addr = r_fetch_pc;
  assign if_valid  = (w_count != '0);
  assign if_inst   = if_valid ? w_head[DATA_W-1:0] : '0;
  assign if_pc     = if_valid ? w_head[EW-1:DATA_W] : '0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_starve;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_starve  <= '0;
    end else begin
      if (w_push && r_perf_fetched != '1)
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (id_ready && !if_valid && r_perf_starve != '1)
        r_perf_starve <= r_perf_starve + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_starve  = r_perf_starve;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a 1-cycle synchronous imem.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_re;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [9:0]  if_pc;
  logic        id_ready;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  inst_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .imem_re        (imem_re),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
  );

  function automatic logic [31:0] img(input logic [9:0] a);
    return 32'hC0DE_0000 ^ {6'b0, a, 6'b0, a};
  endfunction

  always_ff @(posedge clk) begin
    if (imem_re) imem_rdata <= mem[imem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic redirect_to(input logic [9:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [9:0] pc);
    check({tag, "_v"}, 32'(if_valid), 32'd1);
    check({tag, "_pc"}, 32'(if_pc), 32'(pc));
    check({tag, "_inst"}, if_inst, img(pc));
  endtask

  task automatic expect_reset_outs(input string tag);
    check({tag, "_re"}, 32'(imem_re), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_v"}, 32'(if_valid), 32'd0);
    check({tag, "_inst"}, if_inst, 32'd0);
    check({tag, "_pc"}, 32'(if_pc), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = img(10'(i));
    rst            = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    expect_reset_outs("rst");

    // Boot and first stream from RESET_PC
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("boot_re", 32'(imem_re), 32'd0);
    @(negedge clk);
    check("iss0_re", 32'(imem_re), 32'd1);
    check("iss0_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    check("lat_v", 32'(if_valid), 32'd0);
    check("iss1_addr", 32'(imem_addr), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      expect_head($sformatf("s0_%0d", i), 10'(i));
      @(negedge clk);
    end

    // Backpressure: queue fills to DEPTH, then drains in order
    id_ready = 1'b0;
    redirect_to(10'h000);
    check("fl_v", 32'(if_valid), 32'd0);
    repeat (10) @(negedge clk);
    check("full_re", 32'(imem_re), 32'd0);
    check("full_addr", 32'(imem_addr), 32'd4);
    expect_head("full", 10'h000);
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_head($sformatf("drain_%0d", i), 10'(i));
      @(negedge clk);
    end

    // Redirect with 3 queued and 1 in flight
    id_ready = 1'b0;
    redirect_to(10'h000);
    repeat (5) @(negedge clk);
    check("q3_re", 32'(imem_re), 32'd0);
    expect_head("q3", 10'h000);
    id_ready = 1'b1;
    redirect_to(10'h020);
    check("rd_v", 32'(if_valid), 32'd0);
    check("rd_flush_re", 32'(imem_re), 32'd0);
    @(negedge clk);
    check("rd_re", 32'(imem_re), 32'd1);
    check("rd_addr", 32'(imem_addr), 32'h020);
    @(negedge clk);
    check("rd_lat_v", 32'(if_valid), 32'd0);
    @(negedge clk);
    expect_head("rd_first", 10'h020);

    // Wrap around the top of the address space
    redirect_to(10'h3FE);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      expect_head($sformatf("wrap_%0d", i), 10'(10'h3FE + i));
      @(negedge clk);
    end

    // Redirect coinciding with a push and a pop
    redirect_to(10'h100);
    check("rp_v0", 32'(if_valid), 32'd0);
    @(negedge clk);
    check("rp_v1", 32'(if_valid), 32'd0);
    check("rp_addr", 32'(imem_addr), 32'h100);
    @(negedge clk);
    check("rp_v2", 32'(if_valid), 32'd0);
    @(negedge clk);
    expect_head("rp_first", 10'h100);
    @(negedge clk);
    expect_head("rp_next", 10'h101);

    // Asynchronous reset mid-stream, off the clock edge
    #2 rst = 1'b0;
    #1;
    expect_reset_outs("arst");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rb_re", 32'(imem_re), 32'd1);
    check("rb_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    check("rb_lat_v", 32'(if_valid), 32'd0);
    @(negedge clk);
    expect_head("rb_first", 10'h000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
